// File: rtl/signal_source_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : signal_source_mc_if
//  Description : Bus bundle for signal_source_mc. Carries the host memory load
//                path, the downstream FIFO write path and the FIFO almost-full
//                backpressure.
//                  load_we_i / load_addr_i / load_data_i : sample memory load
//                  Afull_i                                : FIFO almost-full
//                  WE_fifo_o / data_o                     : streamed word + valid
//                  addr_Mem_o                             : last issued read addr
//                Modport master = the signal source, slave = host/FIFO side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface signal_source_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int ADDR_W     = 7
);
    logic                           load_we_i;
    logic [ADDR_W-1:0]              load_addr_i;
    logic [CHANNELS*DATA_WIDTH-1:0] load_data_i;
    logic                           Afull_i;
    logic                           WE_fifo_o;
    logic [CHANNELS*DATA_WIDTH-1:0] data_o;
    logic [ADDR_W-1:0]              addr_Mem_o;

    modport master (
        input  load_we_i, load_addr_i, load_data_i, Afull_i,
        output WE_fifo_o, data_o, addr_Mem_o
    );

    modport slave (
        output load_we_i, load_addr_i, load_data_i, Afull_i,
        input  WE_fifo_o, data_o, addr_Mem_o
    );
endinterface
`default_nettype wire

// File: rtl/signal_source_mc.sv
`default_nettype none
// ============================================================================
//  Module      : signal_source_mc
//  Description : Multi-channel stimulus source. Streams a window of a
//                preloaded sample memory (or a ramp) into a downstream FIFO,
//                honouring almost-full backpressure. Modes: one-shot, loop,
//                repeat-N, ramp. Supports stop-on-demand and a status word.
//  Ports       : clk, rst_a (async, active-low)
//                bus          : load path, FIFO write path, backpressure
//                start_i      : one-cycle start pulse (latches cfg_*)
//                stop_i       : one-cycle stop request
//                cfg_length_i : words per pass (1..DEPTH)
//                cfg_offset_i : first memory address
//                cfg_mode_i   : 00 one-shot, 01 loop, 10 repeat-N, 11 ramp
//                cfg_repeat_i : pass count for repeat-N (0 acts as 1)
//                status_reg   : [0] busy [1] done [2] cfg_err [3] load_err
//                               [15:8] completed passes (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module signal_source_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int ADDR_W     = 7
) (
    input  wire logic                 clk,
    input  wire logic                 rst_a,
    signal_source_mc_if.master        bus,
    input  wire logic                 start_i,
    input  wire logic                 stop_i,
    input  wire logic [ADDR_W:0]      cfg_length_i,
    input  wire logic [ADDR_W-1:0]    cfg_offset_i,
    input  wire logic [1:0]           cfg_mode_i,
    input  wire logic [7:0]           cfg_repeat_i,
    output logic [15:0]               status_reg
);

    localparam int              c_DEPTH   = 2**ADDR_W;
    localparam int              c_WORD_W  = CHANNELS*DATA_WIDTH;
    localparam logic [ADDR_W:0] c_DEPTH_L = (ADDR_W+1)'(c_DEPTH);

    localparam logic [1:0] c_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] c_MODE_LOOP    = 2'b01;
    localparam logic [1:0] c_MODE_REPEAT  = 2'b10;
    localparam logic [1:0] c_MODE_RAMP    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_W:0]       r_len;
    logic [ADDR_W-1:0]     r_off;
    logic [1:0]            r_mode;
    logic [7:0]            r_rep;
    logic [ADDR_W:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_k;
    logic [7:0]            r_passes;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cfg_err;
    logic                  r_load_err;
    logic                  r_we;
    logic [c_WORD_W-1:0]   r_data;
    logic [ADDR_W-1:0]     r_addr;

    // Sample memory has no reset so preloaded contents survive rst_a.
    logic [c_WORD_W-1:0]   r_mem [c_DEPTH];

    logic                  w_issue;
    logic [ADDR_W:0]       w_idx_nxt;
    logic                  w_pass_end;
    logic [7:0]            w_passes_inc;
    logic [7:0]            w_rep_eff;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic                  w_cfg_bad;
    logic [c_WORD_W-1:0]   w_ramp_word;

    assign w_issue      = (r_state == S_RUN) && !bus.Afull_i;
    assign w_idx_nxt    = r_idx + 1'b1;
    assign w_pass_end   = w_issue && (w_idx_nxt == r_len);
    assign w_passes_inc = (r_passes == 8'hFF) ? r_passes : r_passes + 8'd1;
    assign w_rep_eff    = (r_rep == 8'd0) ? 8'd1 : r_rep;
    // Natural truncation to ADDR_W bits gives the modulo-DEPTH wrap.
    assign w_rd_addr    = r_off + r_idx[ADDR_W-1:0];
    assign w_cfg_bad    = (cfg_length_i == '0) || (cfg_length_i > c_DEPTH_L);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ramp
        assign w_ramp_word[c*DATA_WIDTH +: DATA_WIDTH] = r_k + DATA_WIDTH'(c);
    end

    // Writes accepted only while idle; a write in the start cycle lands
    // before the first read, which happens in the following cycle.
    always_ff @(posedge clk) begin
        if (bus.load_we_i && (r_state == S_IDLE)) begin
            r_mem[bus.load_addr_i] <= bus.load_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_off      <= '0;
            r_mode     <= c_MODE_ONESHOT;
            r_rep      <= '0;
            r_idx      <= '0;
            r_k        <= '0;
            r_passes   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_load_err <= 1'b0;
            r_we       <= 1'b0;
            r_data     <= '0;
            r_addr     <= '0;
        end else begin
            r_we <= 1'b0;
            if (bus.load_we_i && (r_state != S_IDLE)) begin
                r_load_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_len      <= cfg_length_i;
                        r_off      <= cfg_offset_i;
                        r_mode     <= cfg_mode_i;
                        r_rep      <= cfg_repeat_i;
                        r_idx      <= '0;
                        r_k        <= '0;
                        r_passes   <= '0;
                        r_load_err <= 1'b0;
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_cfg_err <= 1'b0;
                            r_done    <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_we  <= 1'b1;
                        r_k   <= r_k + 1'b1;
                        r_idx <= w_pass_end ? '0 : w_idx_nxt;
                        if (r_mode == c_MODE_RAMP) begin
                            r_data <= w_ramp_word;
                        end else begin
                            r_data <= r_mem[w_rd_addr];
                            r_addr <= w_rd_addr;
                        end
                        if (w_pass_end) begin
                            r_passes <= w_passes_inc;
                        end
                    end
                    // The stop cycle may still issue its word; a pass it
                    // completes is counted, a partial pass is not.
                    if (stop_i) begin
                        r_state <= S_DRAIN;
                    end else if (w_pass_end) begin
                        case (r_mode)
                            c_MODE_LOOP:   r_state <= S_RUN;
                            c_MODE_REPEAT: r_state <= (w_passes_inc >= w_rep_eff) ? S_DRAIN : S_RUN;
                            default:       r_state <= S_DRAIN;
                        endcase
                    end
                end
                S_DRAIN: begin
                    // The last word is on the output this cycle.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.WE_fifo_o  = r_we;
    assign bus.data_o     = r_data;
    assign bus.addr_Mem_o = r_addr;
    assign status_reg     = {r_passes, 4'b0000, r_load_err, r_cfg_err, r_done, r_busy};

endmodule
`default_nettype wire

// File: tb/tb_signal_source_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signal_source_mc
//  Description : Directed self-checking bench for signal_source_mc.
//                Memory word i holds {i+256, i} (channel 0 in LSBs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_source_mc;
    localparam int DW = 32;
    localparam int CH = 2;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    always #5 clk = ~clk;

    signal_source_mc_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .ADDR_W(AW)) bus ();

    logic          start_i = 1'b0;
    logic          stop_i  = 1'b0;
    logic [AW:0]   cfg_length_i = '0;
    logic [AW-1:0] cfg_offset_i = '0;
    logic [1:0]    cfg_mode_i   = '0;
    logic [7:0]    cfg_repeat_i = '0;
    logic [15:0]   status_reg;

    signal_source_mc #(.DATA_WIDTH(DW), .CHANNELS(CH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .bus          (bus),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .cfg_length_i (cfg_length_i),
        .cfg_offset_i (cfg_offset_i),
        .cfg_mode_i   (cfg_mode_i),
        .cfg_repeat_i (cfg_repeat_i),
        .status_reg   (status_reg)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] mem_word(input int a);
        return {32'(a + 256), 32'(a)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int len, input int off, input int mode, input int rep);
        cfg_length_i = 8'(len);
        cfg_offset_i = 7'(off);
        cfg_mode_i   = 2'(mode);
        cfg_repeat_i = 8'(rep);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic load_mem;
        for (int i = 0; i < 128; i++) begin
            bus.load_we_i = 1'b1; bus.load_addr_i = 7'(i); bus.load_data_i = mem_word(i);
            tick();
        end
        bus.load_we_i = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.WE_fifo_o !== 1'b0) begin failures++; $display("FAIL reset_we got %b expected 0", bus.WE_fifo_o); end
        checks++; if (bus.data_o !== 64'd0) begin failures++; $display("FAIL reset_data got %h expected 0", bus.data_o); end
        checks++; if (bus.addr_Mem_o !== 7'd0) begin failures++; $display("FAIL reset_addr got %h expected 0", bus.addr_Mem_o); end
        checks++; if (status_reg !== 16'd0) begin failures++; $display("FAIL reset_status got %h expected 0", status_reg); end
        tick();
        rst_a = 1'b1;
        tick();
    endtask

    task automatic test_one_shot;
        int cnt = 0; int first = -1; int last = -1; int done_cyc = -1;
        start_run(100, 0, 0, 0);
        checks++; if (status_reg[0] !== 1'b1) begin failures++; $display("FAIL oneshot_busy got %b expected 1", status_reg[0]); end
        for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
            tick();
            if (bus.WE_fifo_o) begin
                checks++; if (bus.data_o !== mem_word(cnt)) begin failures++; $display("FAIL oneshot_data[%0d] got %h expected %h", cnt, bus.data_o, mem_word(cnt)); end
                if (first < 0) first = cyc;
                last = cyc; cnt++;
            end
            if (status_reg[1]) done_cyc = cyc;
        end
        checks++; if (cnt !== 100) begin failures++; $display("FAIL oneshot_count got %0d expected 100", cnt); end
        checks++; if (last - first !== 99) begin failures++; $display("FAIL oneshot_span got %0d expected 99", last - first); end
        checks++; if (done_cyc !== last + 1) begin failures++; $display("FAIL oneshot_done_cycle got %0d expected %0d", done_cyc, last + 1); end
        checks++; if (status_reg !== 16'h0102) begin failures++; $display("FAIL oneshot_status got %h expected 0102", status_reg); end
    endtask

    task automatic test_backpressure;
        int cnt = 0; int post_rise = 0; logic af = 1'b0; logic af_n; logic done = 1'b0;
        bus.Afull_i = 1'b0;
        start_run(100, 0, 0, 0);
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            tick();
            af_n = ((cyc / 3) % 2) == 1;
            if (af_n && !af) post_rise = 0;
            af = af_n;
            bus.Afull_i = af;
            if (bus.WE_fifo_o) begin
                checks++; if (bus.data_o !== mem_word(cnt)) begin failures++; $display("FAIL bp_data[%0d] got %h expected %h", cnt, bus.data_o, mem_word(cnt)); end
                cnt++;
                if (af) begin
                    post_rise++;
                    checks++; if (post_rise > 1) begin failures++; $display("FAIL bp_after_afull got %0d words expected <=1", post_rise); end
                end
            end
            done = status_reg[1];
        end
        bus.Afull_i = 1'b0;
        checks++; if (cnt !== 100) begin failures++; $display("FAIL bp_count got %0d expected 100", cnt); end
    endtask

    task automatic test_wrap;
        int cnt = 0; logic done = 1'b0; int a;
        start_run(4, 126, 0, 0);
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            tick();
            if (bus.WE_fifo_o) begin
                a = (126 + cnt) % 128;
                checks++; if (bus.data_o !== mem_word(a)) begin failures++; $display("FAIL wrap_data[%0d] got %h expected %h", cnt, bus.data_o, mem_word(a)); end
                checks++; if (bus.addr_Mem_o !== 7'(a)) begin failures++; $display("FAIL wrap_addr[%0d] got %0d expected %0d", cnt, bus.addr_Mem_o, a); end
                cnt++;
            end
            done = status_reg[1];
        end
        checks++; if (cnt !== 4) begin failures++; $display("FAIL wrap_count got %0d expected 4", cnt); end
    endtask

    task automatic test_repeat_and_stop;
        int cnt = 0; int after = 0; logic stopped = 1'b0; logic done = 1'b0;
        start_run(5, 10, 2, 3);
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            tick();
            if (bus.WE_fifo_o) begin
                checks++; if (bus.data_o !== mem_word(10 + cnt % 5)) begin failures++; $display("FAIL rep_data[%0d] got %h expected %h", cnt, bus.data_o, mem_word(10 + cnt % 5)); end
                cnt++;
            end
            done = status_reg[1];
        end
        checks++; if (cnt !== 15) begin failures++; $display("FAIL rep_count got %0d expected 15", cnt); end
        checks++; if (status_reg[15:8] !== 8'd3) begin failures++; $display("FAIL rep_passes got %0d expected 3", status_reg[15:8]); end
        cnt = 0; done = 1'b0;
        start_run(5, 0, 1, 0);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            tick();
            stop_i = 1'b0;
            if (bus.WE_fifo_o) begin
                checks++; if (bus.data_o !== mem_word(cnt % 5)) begin failures++; $display("FAIL loop_data[%0d] got %h expected %h", cnt, bus.data_o, mem_word(cnt % 5)); end
                cnt++;
                if (stopped) after++;
            end
            if (!stopped && cnt == 12) begin stop_i = 1'b1; stopped = 1'b1; end
            done = status_reg[1];
        end
        checks++; if (!done) begin failures++; $display("FAIL stop_done got %b expected 1", done); end
        checks++; if (after > 1) begin failures++; $display("FAIL stop_words_after got %0d expected <=1", after); end
        checks++; if (status_reg[15:8] !== 8'd2) begin failures++; $display("FAIL stop_passes got %0d expected 2", status_reg[15:8]); end
    endtask

    task automatic test_ramp;
        int cnt = 0; logic done = 1'b0; logic [63:0] e;
        start_run(4, 0, 3, 0);
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            tick();
            if (bus.WE_fifo_o) begin
                e = {32'(cnt + 1), 32'(cnt)};
                checks++; if (bus.data_o !== e) begin failures++; $display("FAIL ramp_data[%0d] got %h expected %h", cnt, bus.data_o, e); end
                cnt++;
            end
            done = status_reg[1];
        end
        checks++; if (cnt !== 4) begin failures++; $display("FAIL ramp_count got %0d expected 4", cnt); end
        checks++; if (status_reg[15:8] !== 8'd1) begin failures++; $display("FAIL ramp_passes got %0d expected 1", status_reg[15:8]); end
    endtask

    task automatic test_errors;
        int we_seen = 0; int cnt = 0; logic done = 1'b0;
        start_run(0, 0, 0, 0);
        checks++; if (status_reg[3:0] !== 4'b0110) begin failures++; $display("FAIL cfgerr_len0 got %b expected 0110", status_reg[3:0]); end
        for (int i = 0; i < 5; i++) begin tick(); if (bus.WE_fifo_o) we_seen++; end
        checks++; if (we_seen !== 0) begin failures++; $display("FAIL cfgerr_we got %0d expected 0", we_seen); end
        start_run(200, 0, 0, 0);
        checks++; if (status_reg[3:0] !== 4'b0110) begin failures++; $display("FAIL cfgerr_len200 got %b expected 0110", status_reg[3:0]); end
        // Hold the FIFO full so the write attempt happens before any read.
        bus.Afull_i = 1'b1;
        start_run(4, 0, 0, 0);
        bus.load_we_i = 1'b1; bus.load_addr_i = 7'd1; bus.load_data_i = '1;
        tick();
        bus.load_we_i = 1'b0;
        checks++; if (status_reg[3] !== 1'b1) begin failures++; $display("FAIL load_err got %b expected 1", status_reg[3]); end
        bus.Afull_i = 1'b0;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            tick();
            if (bus.WE_fifo_o) begin
                checks++; if (bus.data_o !== mem_word(cnt)) begin failures++; $display("FAIL load_err_mem[%0d] got %h expected %h", cnt, bus.data_o, mem_word(cnt)); end
                cnt++;
            end
            done = status_reg[1];
        end
        // Start and write in the same idle cycle: the stream sees the new word.
        bus.load_we_i = 1'b1; bus.load_addr_i = 7'd5; bus.load_data_i = 64'hCAFE_F00D_1234_5678;
        start_run(1, 5, 0, 0);
        bus.load_we_i = 1'b0;
        cnt = 0; done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            tick();
            if (bus.WE_fifo_o) begin
                checks++; if (bus.data_o !== 64'hCAFE_F00D_1234_5678) begin failures++; $display("FAIL start_load_data got %h expected cafef00d12345678", bus.data_o); end
                cnt++;
            end
            done = status_reg[1];
        end
        checks++; if (cnt !== 1) begin failures++; $display("FAIL start_load_count got %0d expected 1", cnt); end
        bus.load_we_i = 1'b1; bus.load_addr_i = 7'd5; bus.load_data_i = mem_word(5);
        tick();
        bus.load_we_i = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int cnt = 0; logic done = 1'b0;
        start_run(100, 0, 0, 0);
        repeat (10) tick();
        rst_a = 1'b0;
        #1;
        checks++; if (bus.WE_fifo_o !== 1'b0) begin failures++; $display("FAIL midrst_we got %b expected 0", bus.WE_fifo_o); end
        checks++; if (bus.data_o !== 64'd0) begin failures++; $display("FAIL midrst_data got %h expected 0", bus.data_o); end
        checks++; if (bus.addr_Mem_o !== 7'd0) begin failures++; $display("FAIL midrst_addr got %h expected 0", bus.addr_Mem_o); end
        checks++; if (status_reg !== 16'd0) begin failures++; $display("FAIL midrst_status got %h expected 0", status_reg); end
        #2 rst_a = 1'b1;
        tick();
        start_run(3, 0, 0, 0);
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            tick();
            if (bus.WE_fifo_o) begin
                checks++; if (bus.data_o !== mem_word(cnt)) begin failures++; $display("FAIL midrst_replay[%0d] got %h expected %h", cnt, bus.data_o, mem_word(cnt)); end
                cnt++;
            end
            done = status_reg[1];
        end
        checks++; if (cnt !== 3) begin failures++; $display("FAIL midrst_replay_count got %0d expected 3", cnt); end
    endtask

    initial begin
        bus.load_we_i   = 1'b0;
        bus.load_addr_i = '0;
        bus.load_data_i = '0;
        bus.Afull_i     = 1'b0;
        test_reset();
        load_mem();
        test_one_shot();
        test_backpressure();
        test_wrap();
        test_repeat_and_stop();
        test_ramp();
        test_errors();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
